// File: rtl/axi_mem_responder_simd.sv
// AXI-style memory responder: a single-port beat-wide backing store with
// independent write (AW/W/B) and read (AR/R) burst engines, one outstanding
// burst per direction. Bursts end on the beat count; wlast is only checked.
module axi_mem_responder_simd #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_MEM_DEPTH        = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  // Write address channel
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  // Write data channel
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  // Write response channel
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  // Read address channel
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  // Read data channel
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,
  // Sticky wlast/awlen mismatch flag
  output logic                              wlast_err
);

  localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned Lsb   = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem_q [C_MEM_DEPTH];

  logic [IdxW-1:0] widx_q, ridx_q;
  logic [7:0]      wcnt_q, rcnt_q;
  logic            wlast_err_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [IdxW-1:0] aw_idx, ar_idx;

  // Only the beat-index slice of each address is meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign aw_idx = s_axi_awaddr[Lsb +: IdxW];
  assign ar_idx = s_axi_araddr[Lsb +: IdxW];

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign b_hs  = s_axi_bvalid  & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid  & s_axi_rready;

  // ---------------------------------------------------------------- write FSM
  // Write state register
  always_ff @(posedge clk) begin
    if (reset) w_state_q <= WIdle;
    else       w_state_q <= w_state_d;
  end

  // Write next-state: the burst ends on the beat count, never on wlast
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      WIdle:   if (aw_hs) w_state_d = WData;
      WData:   if (w_hs && (wcnt_q == 8'd0)) w_state_d = WResp;
      WResp:   if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Write outputs; everything is held low while reset is asserted
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    if (!reset) begin
      case (w_state_q)
        WIdle:   s_axi_awready = 1'b1;
        WData:   s_axi_wready  = 1'b1;
        WResp:   s_axi_bvalid  = 1'b1;
        default: ;
      endcase
    end
  end

  // Write burst index/count and the sticky wlast check
  always_ff @(posedge clk) begin
    if (reset) begin
      widx_q      <= '0;
      wcnt_q      <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        widx_q <= aw_idx;
        wcnt_q <= s_axi_awlen;
      end else if (w_hs && (wcnt_q != 8'd0)) begin
        widx_q <= widx_q + IdxW'(1);
        wcnt_q <= wcnt_q - 8'd1;
      end
      if (w_hs && (s_axi_wlast != (wcnt_q == 8'd0))) wlast_err_q <= 1'b1;
    end
  end

  assign wlast_err = wlast_err_q & ~reset;

  // ----------------------------------------------------------------- read FSM
  // Read state register
  always_ff @(posedge clk) begin
    if (reset) r_state_q <= RIdle;
    else       r_state_q <= r_state_d;
  end

  // Read next-state
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RData;
      RData:   if (r_hs && (rcnt_q == 8'd0)) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Read outputs; everything is held low while reset is asserted
  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    if (!reset) begin
      case (r_state_q)
        RIdle:   s_axi_arready = 1'b1;
        RData: begin
          s_axi_rvalid = 1'b1;
          s_axi_rlast  = (rcnt_q == 8'd0);
        end
        default: ;
      endcase
    end
  end

  // Read burst index/count; ridx_q always points at the next beat to fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      ridx_q <= '0;
      rcnt_q <= '0;
    end else if (ar_hs) begin
      ridx_q <= ar_idx + IdxW'(1);
      rcnt_q <= s_axi_arlen;
    end else if (r_hs && (rcnt_q != 8'd0)) begin
      ridx_q <= ridx_q + IdxW'(1);
      rcnt_q <= rcnt_q - 8'd1;
    end
  end

  // ------------------------------------------------------------------ storage
  // Byte-masked write and registered read; a same-edge read sees the old data
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (s_axi_wstrb[b]) mem_q[widx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
    if (ar_hs) begin
      rdata_q <= mem_q[ar_idx];
    end else if (r_hs && (rcnt_q != 8'd0)) begin
      rdata_q <= mem_q[ridx_q];
    end
  end

  assign s_axi_rdata = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder_simd.sv
// Scoreboard bench for axi_mem_responder_simd: a byte-accurate memory model
// produces the expected read beats, which a monitor pops on each R handshake.
module tb_axi_mem_responder_simd;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast, wlast_err;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;
  logic [7:0]    wstrb;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf  [16];
  logic          exp_err = 1'b0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  axi_mem_responder_simd #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_MEM_DEPTH       (DEPTH)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_awaddr (awaddr),
    .s_axi_awlen  (awlen),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wlast  (wlast),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_araddr (araddr),
    .s_axi_arlen  (arlen),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .s_axi_rdata  (rdata),
    .s_axi_rlast  (rlast),
    .wlast_err    (wlast_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // R monitor: pops the scoreboard on handshakes and checks hold during stalls
  logic          stall_q = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  always @(negedge clk) begin
    beat_t b;
    if (!reset && stall_q) begin
      chk("r_hold_valid", 64'(rvalid), 64'd1);
      chk("r_hold_data", rdata, held_data);
      chk("r_hold_last", 64'(rlast), 64'(held_last));
    end
    if (!reset && rvalid && rready) begin
      if (exp_q.size() == 0) begin
        chk("r_extra_beat", 64'd1, 64'd0);
      end else begin
        b = exp_q.pop_front();
        chk("r_data", rdata, b.data);
        chk("r_last", 64'(rlast), 64'(b.last));
      end
    end
    stall_q   = !reset && rvalid && !rready;
    held_data = rdata;
    held_last = rlast;
  end

  function automatic int beat_idx(input logic [AW-1:0] addr);
    return int'((addr >> 3) & AW'(DEPTH - 1));
  endfunction

  // Caller is positioned just after a rising edge; returns likewise.
  task automatic write_burst(input logic [AW-1:0] addr, input int len,
                             input logic [7:0] strb, input int wlast_beat);
    int n;
    int idx;
    idx     = beat_idx(addr);
    awvalid = 1'b1;
    awaddr  = addr;
    awlen   = 8'(len);
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) chk("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      wvalid = 1'b1;
      wdata  = wbuf[k];
      wstrb  = strb;
      wlast  = (wlast_beat < 0) ? (k == len) : (k == wlast_beat);
      n = 0;
      @(negedge clk);
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) chk("w_timeout", 64'd0, 64'd1);
      for (int b = 0; b < 8; b++) begin
        if (strb[b]) model[(idx + k) % DEPTH][8*b +: 8] = wbuf[k][8*b +: 8];
      end
      if (wlast != (k == len)) exp_err = 1'b1;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    @(negedge clk);
    chk("b_latency", 64'(bvalid), 64'd1);
    chk("wlast_err", 64'(wlast_err), 64'(exp_err));
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("b_cleared", 64'(bvalid), 64'd0);
    chk("aw_after_b", 64'(awready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic push_expect(input logic [AW-1:0] addr, input int len);
    int idx;
    idx = beat_idx(addr);
    for (int k = 0; k <= len; k++) exp_q.push_back('{model[(idx + k) % DEPTH], (k == len)});
  endtask

  task automatic send_ar(input logic [AW-1:0] addr, input int len);
    int n;
    arvalid = 1'b1;
    araddr  = addr;
    arlen   = 8'(len);
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int len, input bit stall);
    int n;
    push_expect(addr, len);
    send_ar(addr, len);
    rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    chk("r_latency", 64'(rvalid), 64'd1);
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk); #1;
      rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (n >= 300) chk("r_timeout", 64'd0, 64'd1);
    rready = 1'b0;
    @(negedge clk);
    chk("r_done_idle", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset   = 1'b1;
    awvalid = 1'b0; awaddr = '0; awlen = '0;
    wvalid  = 1'b0; wdata  = '0; wstrb = '0; wlast = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0; araddr = '0; arlen = '0;
    rready  = 1'b0;

    @(negedge clk);
    chk("rst_outputs", 64'({awready, arready, wready, bvalid, rvalid, rlast, wlast_err}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;

    // Single beat write then read, plus an unaligned alias of the same beat
    wbuf[0] = {8{8'hA5}};
    write_burst(32'h40, 0, 8'hFF, -1);
    read_burst(32'h40, 0, 1'b0);
    read_burst(32'h45, 0, 1'b0);

    // 16-beat burst filling the whole store, read back with random stalls
    for (int k = 0; k < 16; k++) wbuf[k] = 64'(k);
    write_burst(32'h0, 15, 8'hFF, -1);
    read_burst(32'h0, 15, 1'b1);

    // Partial strobe: only byte 0 is overwritten
    wbuf[0] = '1;
    write_burst(32'h18, 0, 8'hFF, -1);
    wbuf[0] = '0;
    write_burst(32'h18, 0, 8'h01, -1);
    push_expect(32'h18, 0);
    chk("strb_expect", exp_q[0].data, 64'hFFFF_FFFF_FFFF_FF00);
    exp_q.delete();
    read_burst(32'h18, 0, 1'b0);

    // Wrap-around from the last two indices back to 0 and 1
    for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
    write_burst(32'h70, 3, 8'hFF, -1);
    read_burst(32'h70, 3, 1'b1);
    read_burst(32'h0, 1, 1'b0);

    // wlast on beat 1 of a 4-beat burst: all 4 beats still land
    for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
    write_burst(32'h20, 3, 8'hFF, 1);
    read_burst(32'h20, 3, 1'b0);
    @(negedge clk);
    chk("wlast_err_sticky", 64'(wlast_err), 64'd1);
    @(posedge clk); #1;

    // Reset while beat 2 of an 8-beat read is presented
    push_expect(32'h0, 7);
    send_ar(32'h0, 7);
    rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    chk("beat2_valid", 64'(rvalid), 64'd1);
    chk("beats_left", 64'(exp_q.size()), 64'd6);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    chk("rst_rvalid_after", 64'(rvalid), 64'd0);
    chk("rst_arready_after", 64'(arready), 64'd1);
    chk("rst_wlast_err", 64'(wlast_err), 64'd0);
    @(posedge clk); #1;

    // Store contents survive reset and the read path recovers
    read_burst(32'h40, 0, 1'b0);
    read_burst(32'h8, 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
